// File: rtl/sub_arb_pkg.sv
// Shared types for the arbitrated input pipe: arbitration mode and the
// channel-index width helper.
package sub_arb_pkg;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   // Width of a channel index; never less than one bit.
   function automatic int chan_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sub_arb_pipe_arbiter.sv
// Combinational grant: round-robin search from ptr with wrap, or fixed
// priority where the lowest requesting index wins.
module sub_rr_arbiter
   import sub_arb_pkg::*;
#(
   parameter int  NCHAN  = 4,
   localparam int CHAN_W = chan_w(NCHAN)
) (
   input  logic [NCHAN-1:0]  req,
   input  logic [CHAN_W-1:0] ptr,
   input  arb_mode_e         mode,
   output logic [NCHAN-1:0]  grant,
   output logic [CHAN_W-1:0] idx
);

   logic w_found;
   int   w_c;

   always_comb begin
      grant   = '0;
      idx     = '0;
      w_found = 1'b0;
      w_c     = 0;
      for (int k = 0; k < NCHAN; k++) begin
         w_c = (mode == ARB_FIXED) ? k : (int'(ptr) + k) % NCHAN;
         if (!w_found && req[w_c]) begin
            w_found    = 1'b1;
            grant[w_c] = 1'b1;
            idx        = CHAN_W'(w_c);
         end
      end
   end

endmodule

// File: rtl/sub_arb_pipe.sv
// N-channel arbiter feeding a single registered output slot with
// valid/ready handshake on both sides and a wrapping transfer counter.
module sub_arb_pipe
   import sub_arb_pkg::*;
#(
   parameter int        NCHAN    = 4,
   parameter int        WIDTH    = 8,
   parameter arb_mode_e ARB_MODE = ARB_RR,
   localparam int       CHAN_W   = chan_w(NCHAN)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCHAN-1:0]       in_valid,
   input  logic [NCHAN*WIDTH-1:0] in_data,
   output logic [NCHAN-1:0]       in_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   output logic [CHAN_W-1:0]      out_chan,
   input  logic                   out_ready,
   output logic [15:0]            xfer_cnt
);

   logic              r_valid;
   logic [WIDTH-1:0]  r_data;
   logic [CHAN_W-1:0] r_chan;
   logic [CHAN_W-1:0] r_ptr;
   logic [15:0]       r_cnt;

   logic              w_slot_free;
   logic [NCHAN-1:0]  w_grant;
   logic [CHAN_W-1:0] w_idx;
   logic              w_in_xfer;
   logic              w_out_xfer;
   logic [CHAN_W-1:0] w_ptr_nxt;

   sub_rr_arbiter #(.NCHAN(NCHAN)) u_arb (
      .req   (in_valid),
      .ptr   (r_ptr),
      .mode  (ARB_MODE),
      .grant (w_grant),
      .idx   (w_idx)
   );

   assign w_slot_free = !r_valid || out_ready;
   // Grant is nonzero exactly when some channel requests, so the input
   // transfer needs no per-channel AND-reduction.
   assign w_in_xfer   = rst_n && w_slot_free && (|in_valid);
   assign w_out_xfer  = r_valid && out_ready;
   assign in_ready    = (rst_n && w_slot_free) ? w_grant : '0;
   assign w_ptr_nxt   = (w_idx == CHAN_W'(NCHAN - 1)) ? '0 : w_idx + CHAN_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_chan  <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_in_xfer) begin
            r_valid <= 1'b1;
            r_data  <= in_data[int'(w_idx)*WIDTH +: WIDTH];
            r_chan  <= w_idx;
            r_ptr   <= w_ptr_nxt;
         end else if (w_out_xfer) begin
            r_valid <= 1'b0;
         end
         if (w_out_xfer) r_cnt <= r_cnt + 16'd1;
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_chan  = r_chan;
   assign xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_sub_arb_pipe.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share one
// stimulus stream; a queue-based model predicts grants and output payloads.
module tb_sub_arb_pipe;
   import sub_arb_pkg::*;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [N-1:0] in_valid = '0;
   logic [N*W-1:0] in_data = '0;
   logic         out_ready = 1'b0;

   logic [N-1:0] rdy [2];
   logic         ov  [2];
   logic [W-1:0] od  [2];
   logic [1:0]   oc  [2];
   logic [15:0]  xc  [2];

   int total = 0;
   int bad   = 0;

   int       q0[$];
   int       q1[$];
   int       ptr_m  [2];
   int       cnt_m  [2];
   bit       occ_m  [2];
   bit       stall_p[2];
   logic [W-1:0] data_p[2];

   sub_arb_pipe #(.NCHAN(N), .WIDTH(W), .ARB_MODE(ARB_RR)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_chan(oc[0]),
      .out_ready(out_ready), .xfer_cnt(xc[0])
   );

   sub_arb_pipe #(.NCHAN(N), .WIDTH(W), .ARB_MODE(ARB_FIXED)) u_fx (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_chan(oc[1]),
      .out_ready(out_ready), .xfer_cnt(xc[1])
   );

   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic void clear_model();
      for (int m = 0; m < 2; m++) begin
         ptr_m[m]   = 0;
         cnt_m[m]   = 0;
         occ_m[m]   = 1'b0;
         stall_p[m] = 1'b0;
      end
      q0.delete();
      q1.delete();
   endfunction

   // Stimulus-side model: predicts grant from the rules and queues the
   // payload expected to appear on the output.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int m = 0; m < 2; m++) begin
            int g;
            int c;
            int e;
            bit free;
            chk($sformatf("out_valid%0d", m), 32'(ov[m]), 32'(occ_m[m]));
            free = !occ_m[m] || out_ready;
            g = -1;
            if (free) begin
               for (int k = 0; k < N; k++) begin
                  c = (m == 0) ? (ptr_m[m] + k) % N : k;
                  if (g < 0 && in_valid[c]) g = c;
               end
            end
            chk($sformatf("in_ready%0d", m), 32'(rdy[m]), (g < 0) ? 32'd0 : 32'(1 << g));
            if (g >= 0) begin
               e = g * 256 + int'(in_data[g*W +: W]);
               if (m == 0) q0.push_back(e); else q1.push_back(e);
               occ_m[m] = 1'b1;
               ptr_m[m] = (g + 1) % N;
            end else if (occ_m[m] && out_ready) begin
               occ_m[m] = 1'b0;
            end
         end
      end
   end

   // Monitor: pops on each output transfer and checks payload, counter and
   // stability of held data during a stall.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int m = 0; m < 2; m++) begin
            int e;
            bit have;
            if (stall_p[m]) chk($sformatf("hold_data%0d", m), 32'(od[m]), 32'(data_p[m]));
            if (ov[m] && out_ready) begin
               chk($sformatf("xfer_cnt%0d", m), 32'(xc[m]), 32'(cnt_m[m] & 32'hFFFF));
               have = (m == 0) ? (q0.size() > 0) : (q1.size() > 0);
               if (!have) begin
                  total++;
                  bad++;
                  $display("FAIL scoreboard_empty%0d act=out_valid exp=no_output", m);
               end else begin
                  if (m == 0) e = q0.pop_front(); else e = q1.pop_front();
                  chk($sformatf("out_chan%0d", m), 32'(oc[m]), 32'(e / 256));
                  chk($sformatf("out_data%0d", m), 32'(od[m]), 32'(e % 256));
               end
               cnt_m[m]++;
            end
            stall_p[m] = ov[m] && !out_ready;
            data_p[m]  = od[m];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_model();
      #1;
      for (int m = 0; m < 2; m++) begin
         chk("rst_out_valid", 32'(ov[m]), 32'd0);
         chk("rst_out_data",  32'(od[m]), 32'd0);
         chk("rst_out_chan",  32'(oc[m]), 32'd0);
         chk("rst_xfer_cnt",  32'(xc[m]), 32'd0);
         chk("rst_in_ready",  32'(rdy[m]), 32'd0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int guard;
      #1;
      do_reset();

      // single request on lane 2
      in_valid  = 4'b0100;
      in_data   = 32'h00A5_0000;
      out_ready = 1'b1;
      tick();
      in_valid = '0;
      chk("single_valid", 32'(ov[0]), 32'd1);
      chk("single_data",  32'(od[0]), 32'hA5);
      chk("single_chan",  32'(oc[0]), 32'd2);
      tick();
      chk("single_cnt", 32'(xc[0]), 32'd1);

      // round-robin fairness from a fresh pointer
      do_reset();
      in_valid  = 4'hF;
      in_data   = 32'h4433_2211;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rr_seq", 32'(oc[0]), 32'(i % 4));
         chk("fx_seq", 32'(oc[1]), 32'd0);
      end

      // fixed priority with channels 1 and 3 requesting
      in_valid = 4'b1010;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("fx_chan", 32'(oc[1]), 32'd1);
         chk("fx_rdy3", 32'(rdy[1][3]), 32'd0);
      end
      in_valid = '0;
      tick();

      // backpressure
      do_reset();
      in_valid  = 4'b0001;
      in_data   = 32'h0000_003C;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_data   = 32'h0000_0077;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_data",  32'(od[0]), 32'h3C);
         chk("bp_ready", 32'(rdy[0]), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_accept", 32'(rdy[0]), 32'd1);
      tick();
      chk("bp_next_data", 32'(od[0]), 32'h77);
      in_valid = '0;
      tick();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = 4'($urandom_range(0, 15));
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      // reset while stalled
      in_valid  = 4'b0100;
      out_ready = 1'b0;
      tick();
      tick();
      chk("stall_before_rst", 32'(ov[0]), 32'd1);
      in_valid = 4'b0110;
      do_reset();
      #1;
      chk("post_rst_grant_rr", 32'(rdy[0]), 32'b0010);
      chk("post_rst_grant_fx", 32'(rdy[1]), 32'b0010);
      out_ready = 1'b1;
      tick();

      // counter wrap under continuous traffic
      in_valid = 4'hF;
      guard = 0;
      while (cnt_m[0] < 65535 && guard < 70000) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (cnt_m[0] < 65535) begin
         total++;
         bad++;
         $display("FAIL wrap_reach act=%0d exp=65535", cnt_m[0]);
      end
      tick();
      chk("wrap_ffff", 32'(xc[0]), 32'hFFFF);
      tick();
      chk("wrap_zero", 32'(xc[0]), 32'h0000);

      in_valid = '0;
      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
